// File: rtl/uart_rx_block.sv
// 8N1 UART receiver that emits each correctly framed byte and assembles
// consecutive bytes into 16-byte blocks, first byte in the top octet.
module uart_rx_block #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_in,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  output logic [127:0] block_out,
  output logic         block_valid,
  output logic         frame_err,
  output logic         busy
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t         state;
  logic           rx_p0;
  logic           rx_s;
  logic [15:0]    timer;
  logic [2:0]     bit_idx;
  logic [7:0]     shift_reg;
  logic [3:0]     byte_cnt;
  logic [119:0]   partial;

  // Stage p0/p1: two-flop synchronizer; idle-high reset value keeps the FSM quiet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx_in;
      rx_s  <= rx_p0;
    end
  end

  // Framing FSM, byte capture and block assembly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= 16'd0;
      bit_idx     <= 3'd0;
      shift_reg   <= 8'd0;
      byte_cnt    <= 4'd0;
      partial     <= 120'd0;
      byte_out    <= 8'd0;
      block_out   <= 128'd0;
      byte_valid  <= 1'b0;
      block_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      block_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          timer <= 16'd0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer   <= 16'd0;
            bit_idx <= 3'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DATA: begin
          if (timer == FULL_LAST) begin
            timer     <= 16'd0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        STOP: begin
          if (timer == FULL_LAST) begin
            timer <= 16'd0;
            if (rx_s) begin
              state      <= IDLE;
              busy       <= 1'b0;
              byte_out   <= shift_reg;
              byte_valid <= 1'b1;
              byte_cnt   <= byte_cnt + 4'd1;
              // The 16th byte completes the block; the partial register restarts empty
              if (byte_cnt == 4'd15) begin
                block_out   <= {partial, shift_reg};
                block_valid <= 1'b1;
                partial     <= 120'd0;
              end else begin
                partial <= {partial[111:0], shift_reg};
              end
            end else begin
              state     <= WAIT_HIGH;
              frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        WAIT_HIGH: begin
          timer <= 16'd0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_block.sv
// Bench for uart_rx_block: table-driven single frames, hand sequences for
// glitch/break/reset, and random byte streams checked against a queue model.
module tb_uart_rx_block;

  localparam int CPB = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_in = 1'b1;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic [127:0] block_out;
  logic         block_valid;
  logic         frame_err;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int blk_cnt = 0;

  logic [7:0]   exp_q[$];
  logic [7:0]   blk_q[$];
  logic [127:0] last_blk_exp = 128'd0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_bv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[5];

  uart_rx_block #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in),
    .byte_out(byte_out), .byte_valid(byte_valid),
    .block_out(block_out), .block_valid(block_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ideal transmitter: the model expects every frame with a high stop bit
  task automatic send_frame(input logic [7:0] d, input logic stop);
    if (stop) exp_q.push_back(d);
    rx_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (CPB) tick();
    end
    rx_in = stop;
    repeat (CPB) tick();
  endtask

  task automatic reset_dut(input logic rx_level);
    reset = 1'b1;
    rx_in = rx_level;
    exp_q.delete();
    blk_q.delete();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // Reference model: accepted bytes in arrival order, grouped in sixteens
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) fe_cnt++;
      if (block_valid) blk_cnt++;
      if (byte_valid) begin
        logic [7:0]   e;
        logic [127:0] eb;
        bv_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte_valid", 128'(byte_valid), 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("byte_out", 128'(byte_out), 128'(e));
          blk_q.push_back(e);
          if (blk_q.size() == 16) begin
            eb = 128'd0;
            for (int i = 0; i < 16; i++) eb = {eb[119:0], blk_q[i]};
            check("block_valid_coincident", 128'(block_valid), 128'd1);
            check("block_out_model", block_out, eb);
            last_blk_exp = eb;
            blk_q.delete();
          end else begin
            check("block_valid_early", 128'(block_valid), 128'd0);
          end
        end
      end else if (block_valid) begin
        check("block_valid_alone", 128'(block_valid), 128'd0);
      end
    end
  end

  initial begin
    int bv0, fe0, bk0, i_cnt;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h55, 1'b1, 1, 0, 8'h55};

    reset_dut(1'b1);
    tick();
    check("reset_byte_out", 128'(byte_out), 128'd0);
    check("reset_block_out", block_out, 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_strobes", 128'({byte_valid, block_valid, frame_err}), 128'd0);

    // Two-cycle low glitch must be rejected
    bv0 = bv_cnt; fe0 = fe_cnt; bk0 = blk_cnt;
    rx_in = 1'b0;
    repeat (2) tick();
    rx_in = 1'b1;
    i_cnt = 0;
    repeat (3) tick();
    while (busy && i_cnt < CPB / 2 + 3) begin
      tick();
      i_cnt++;
    end
    check("glitch_busy_idle", 128'(busy), 128'd0);
    repeat (CPB) tick();
    check("glitch_strobes", 128'((bv_cnt - bv0) + (fe_cnt - fe0) + (blk_cnt - bk0)), 128'd0);

    // Single frames, including a broken stop bit followed by a long break
    for (int v = 0; v < 5; v++) begin
      bv0 = bv_cnt; fe0 = fe_cnt; bk0 = blk_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      if (!vecs[v].stop) begin
        repeat (40 * CPB) tick();
        rx_in = 1'b1;
      end
      repeat (4) tick();
      check($sformatf("vec%0d_byte_valid", v), 128'(bv_cnt - bv0), 128'(vecs[v].exp_bv));
      check($sformatf("vec%0d_frame_err", v), 128'(fe_cnt - fe0), 128'(vecs[v].exp_fe));
      check($sformatf("vec%0d_byte_out", v), 128'(byte_out), 128'(vecs[v].exp_byte));
      check($sformatf("vec%0d_block_valid", v), 128'(blk_cnt - bk0), 128'd0);
    end

    // Twelve random bytes complete the block started by the four accepted above
    bk0 = blk_cnt;
    for (int n = 0; n < 12; n++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    repeat (4) tick();
    check("fill_block_count", 128'(blk_cnt - bk0), 128'd1);

    // Sixteen back-to-back bytes 0x00..0x0F
    bv0 = bv_cnt; bk0 = blk_cnt;
    for (int n = 0; n < 16; n++) send_frame(8'(n), 1'b1);
    repeat (4) tick();
    check("seq_byte_count", 128'(bv_cnt - bv0), 128'd16);
    check("seq_block_count", 128'(blk_cnt - bk0), 128'd1);
    check("seq_block_out", block_out, 128'h000102030405060708090A0B0C0D0E0F);

    // Random stream of two blocks
    bk0 = blk_cnt;
    for (int n = 0; n < 32; n++) send_frame(8'($urandom), 1'b1);
    repeat (4) tick();
    check("rand_block_count", 128'(blk_cnt - bk0), 128'd2);

    // Five bytes then half a sixth: block_out must hold, then reset discards all
    for (int n = 0; n < 5; n++) send_frame(8'($urandom), 1'b1);
    repeat (2) tick();
    check("block_hold", block_out, last_blk_exp);
    rx_in = 1'b0;
    repeat (CPB) tick();
    rx_in = 1'b1;
    repeat (CPB + CPB / 2) tick();
    reset_dut(1'b0);
    #1;
    check("midframe_reset_block", block_out, 128'd0);
    check("midframe_reset_byte", 128'(byte_out), 128'd0);
    check("midframe_reset_busy", 128'(busy), 128'd0);

    // Line still low at release: first frame's start bit begins at release
    bv0 = bv_cnt; bk0 = blk_cnt;
    for (int n = 0; n < 16; n++) send_frame(8'(8'hF0 + n), 1'b1);
    repeat (4) tick();
    check("post_reset_byte_count", 128'(bv_cnt - bv0), 128'd16);
    check("post_reset_block_count", 128'(blk_cnt - bk0), 128'd1);
    check("post_reset_block_out", block_out, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    check("model_queue_drained", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
